// File: rtl/qed_dup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qed_dup_ctrl_pkg
// Purpose : Shared definitions for the QED duplication sequencer: the NOP
//           opcode recognised by both the sequencer and the instruction
//           cache, and the 2-bit mode encoding.
// Revision: 1.0 - initial release
// ============================================================================
package qed_dup_ctrl_pkg;

  localparam logic [6:0] QED_NOP_OPCODE = 7'h7F;

  typedef enum logic [1:0] {
    QED_OFF  = 2'd0,
    QED_ORIG = 2'd1,
    QED_DUP  = 2'd2
  } qed_state_e;

  function automatic logic qed_is_nop(input logic [6:0] opcode);
    return opcode == QED_NOP_OPCODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qed_dup_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : qed_sat_counter
// Purpose : Saturating up-counter with synchronous clear.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           inc        - add one (ignored once saturated)
//           clr        - clear to zero (wins over inc)
//           value      - current count
//           sat        - count is at all-ones
// Revision: 1.0 - initial release
// ============================================================================
module qed_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         sat
);

  logic [W-1:0] r_value;

  assign value = r_value;
  assign sat   = &r_value;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_value <= '0;
    end else if (inc && !sat) begin
      r_value <= r_value + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/qed_dup_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : qed_dup_ctrl
// Purpose : Mode sequencer in front of the QED instruction cache. Mirrors the
//           cache occupancy, decides when to stop storing originals and
//           start replaying duplicates, and returns to original mode once
//           every stored instruction has been replayed.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           qed_ena              - QED enable (0 = pass-through)
//           IF_stall             - fetch stall shared with the cache
//           ifu_qed_instruction  - fetched instruction
//           switch_req           - request to enter duplicate mode
//           exec_dup             - 1 while the cache replays duplicates
//           pending              - originals stored, not yet replayed
//           orig_cnt / dup_cnt   - originals / duplicates this batch series
//           qed_ready            - 1-cycle pulse when a batch fully drains
//           ovf_err              - sticky error flag
// Revision: 1.0 - initial release
// ============================================================================
module qed_dup_ctrl
  import qed_dup_ctrl_pkg::*;
#(
  parameter int QDEPTH = 128,
  parameter int PEND_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qed_ena,
  input  logic              IF_stall,
  input  logic [31:0]       ifu_qed_instruction,
  input  logic              switch_req,
  output logic              exec_dup,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  orig_cnt,
  output logic [CNT_W-1:0]  dup_cnt,
  output logic              qed_ready,
  output logic              ovf_err
);

  // One slot is always kept free so the cache can tell full from empty.
  localparam logic [PEND_W-1:0] c_full = PEND_W'(QDEPTH - 1);

  qed_state_e        r_state;
  logic              r_exec_dup;
  logic [PEND_W-1:0] r_pending;
  logic              r_qed_ready;
  logic              r_ovf_err;

  logic              w_is_nop;
  logic              w_ins_try, w_ins, w_ins_ovf;
  logic              w_del_try, w_del, w_del_udf;
  logic [PEND_W-1:0] w_pending_nxt;
  logic              w_orig_sat, w_dup_sat;
  logic              w_cnt_clr;
  logic [CNT_W-1:0]  w_dup_nxt;
  logic              w_drain;
  logic              w_cnt_match;
  logic              w_err_set;
  logic              w_unused_instr;

  assign w_unused_instr = ^ifu_qed_instruction[31:7];
  assign w_is_nop       = qed_is_nop(ifu_qed_instruction[6:0]);

  // Insert/delete events follow exactly the cache's own rules so the mirrored
  // occupancy can never drift from the real one.
  assign w_ins_try = (r_state == QED_ORIG) && !r_exec_dup && !w_is_nop && !IF_stall;
  assign w_ins     = w_ins_try && (r_pending != c_full);
  assign w_ins_ovf = w_ins_try && (r_pending == c_full);

  assign w_del_try = (r_state == QED_DUP) && r_exec_dup && !IF_stall;
  assign w_del     = w_del_try && (r_pending != '0);
  assign w_del_udf = w_del_try && (r_pending == '0);

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ins) begin
      w_pending_nxt = r_pending + PEND_W'(1);
    end else if (w_del) begin
      w_pending_nxt = r_pending - PEND_W'(1);
    end
  end

  // Counters restart when a new batch series begins (OFF -> ORIG).
  assign w_cnt_clr = (r_state == QED_OFF) && qed_ena;

  qed_sat_counter #(.W(CNT_W)) u_orig_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_ins),
    .clr   (w_cnt_clr),
    .value (orig_cnt),
    .sat   (w_orig_sat)
  );

  qed_sat_counter #(.W(CNT_W)) u_dup_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_del),
    .clr   (w_cnt_clr),
    .value (dup_cnt),
    .sat   (w_dup_sat)
  );

  // The drain decision is taken on the edge that retires the last duplicate,
  // so compare against the duplicate count as it will be after that edge.
  assign w_dup_nxt   = (w_del && !w_dup_sat) ? dup_cnt + CNT_W'(1) : dup_cnt;
  assign w_drain     = (r_state == QED_DUP) && (w_pending_nxt == '0);
  assign w_cnt_match = (orig_cnt == w_dup_nxt);

  assign w_err_set = w_ins_ovf || w_del_udf ||
                     (w_ins && w_orig_sat) || (w_del && w_dup_sat) ||
                     (w_drain && !w_cnt_match);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= QED_OFF;
      r_exec_dup  <= 1'b0;
      r_pending   <= '0;
      r_qed_ready <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_qed_ready <= w_drain && w_cnt_match;
      if (w_err_set) begin
        r_ovf_err <= 1'b1;
      end
      case (r_state)
        QED_OFF: begin
          if (qed_ena) begin
            r_state <= QED_ORIG;
          end
          r_exec_dup <= 1'b0;
        end
        QED_ORIG: begin
          if (!qed_ena) begin
            r_state    <= QED_OFF;
            r_exec_dup <= 1'b0;
          end else if ((w_pending_nxt != '0) &&
                       (switch_req || (w_pending_nxt == c_full))) begin
            // A full cache forces replay; an empty one cannot switch.
            r_state    <= QED_DUP;
            r_exec_dup <= 1'b1;
          end else begin
            r_exec_dup <= 1'b0;
          end
        end
        QED_DUP: begin
          // Requests and enable are only honoured once fully drained.
          if (w_pending_nxt == '0) begin
            r_state    <= qed_ena ? QED_ORIG : QED_OFF;
            r_exec_dup <= 1'b0;
          end else begin
            r_exec_dup <= 1'b1;
          end
        end
        default: begin
          r_state    <= QED_OFF;
          r_exec_dup <= 1'b0;
        end
      endcase
    end
  end

  assign exec_dup  = r_exec_dup;
  assign pending   = r_pending;
  assign qed_ready = r_qed_ready;
  assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_qed_dup_ctrl
// Purpose : Self-checking bench for qed_dup_ctrl: directed scenarios with
//           literal expectations, then randomized traffic, all compared each
//           cycle against a mode/occupancy model of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_qed_dup_ctrl;

  localparam int QDEPTH = 128;
  localparam int PEND_W = 8;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] c_op  = 32'h0000_0013;
  localparam logic [31:0] c_nop = 32'h0000_007F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              qed_ena = 1'b0;
  logic              IF_stall = 1'b0;
  logic [31:0]       ifu_qed_instruction = 32'h0;
  logic              switch_req = 1'b0;
  logic              exec_dup;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  orig_cnt;
  logic [CNT_W-1:0]  dup_cnt;
  logic              qed_ready;
  logic              ovf_err;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  qed_dup_ctrl #(.QDEPTH(QDEPTH), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .qed_ena             (qed_ena),
    .IF_stall            (IF_stall),
    .ifu_qed_instruction (ifu_qed_instruction),
    .switch_req          (switch_req),
    .exec_dup            (exec_dup),
    .pending             (pending),
    .orig_cnt            (orig_cnt),
    .dup_cnt             (dup_cnt),
    .qed_ready           (qed_ready),
    .ovf_err             (ovf_err)
  );

  // ---------------------------------------------------------------- model
  // mode: 0 = off, 1 = storing originals, 2 = replaying duplicates
  int m_mode = 0;
  int m_pend = 0;
  int m_orig = 0;
  int m_dup  = 0;
  bit m_ready = 1'b0;
  bit m_err   = 1'b0;

  always @(posedge clk) begin
    bit store, replay, nop;
    int nxt;
    if (rst) begin
      m_mode = 0; m_pend = 0; m_orig = 0; m_dup = 0; m_ready = 0; m_err = 0;
    end else begin
      nop    = (ifu_qed_instruction[6:0] == 7'h7F);
      store  = (m_mode == 1) && !nop && !IF_stall;
      replay = (m_mode == 2) && !IF_stall;
      nxt = m_pend;
      if (store) begin
        if (m_pend == QDEPTH - 1) m_err = 1;
        else begin
          nxt = m_pend + 1;
          if (m_orig == CMAX) m_err = 1; else m_orig = m_orig + 1;
        end
      end
      if (replay) begin
        if (m_pend == 0) m_err = 1;
        else begin
          nxt = m_pend - 1;
          if (m_dup == CMAX) m_err = 1; else m_dup = m_dup + 1;
        end
      end
      m_ready = 0;
      case (m_mode)
        0: if (qed_ena) begin m_mode = 1; m_orig = 0; m_dup = 0; end
        1: if (!qed_ena) m_mode = 0;
           else if (nxt != 0 && (switch_req || nxt == QDEPTH - 1)) m_mode = 2;
        default: if (nxt == 0) begin
             m_mode = qed_ena ? 1 : 0;
             if (m_orig == m_dup) m_ready = 1; else m_err = 1;
           end
      endcase
      m_pend = nxt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("exec_dup",  int'(exec_dup),  (m_mode == 2) ? 1 : 0);
      chk("pending",   int'(pending),   m_pend);
      chk("orig_cnt",  int'(orig_cnt),  m_orig);
      chk("dup_cnt",   int'(dup_cnt),   m_dup);
      chk("qed_ready", int'(qed_ready), int'(m_ready));
      chk("ovf_err",   int'(ovf_err),   int'(m_err));
    end
  end

  // ------------------------------------------------------------- stimulus
  // Drive one cycle's inputs at the falling edge, then settle after the
  // rising edge so literal checks see the post-edge outputs.
  task automatic step(input bit r, input bit ena, input bit stall,
                      input bit sw, input logic [31:0] instr);
    @(negedge clk);
    rst = r; qed_ena = ena; IF_stall = stall; switch_req = sw;
    ifu_qed_instruction = instr;
    @(posedge clk);
    #1;
  endtask

  int ready_seen;

  initial begin
    // 1. reset, then enable
    repeat (3) step(1, 0, 0, 0, c_op);
    chk_on = 1'b1;
    chk("rst exec_dup", int'(exec_dup), 0);
    chk("rst pending",  int'(pending),  0);
    chk("rst ovf_err",  int'(ovf_err),  0);
    step(0, 1, 0, 0, c_op);
    chk("enter orig exec_dup", int'(exec_dup), 0);
    chk("enter orig orig_cnt", int'(orig_cnt), 0);

    // 2. five originals, switch on the fifth, then five replays
    for (int i = 0; i < 5; i++) step(0, 1, 0, (i == 4), c_op);
    chk("t2 exec_dup", int'(exec_dup), 1);
    chk("t2 pending",  int'(pending),  5);
    chk("t2 orig_cnt", int'(orig_cnt), 5);
    ready_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, c_op);
      ready_seen += int'(qed_ready);
    end
    chk("t2 drained exec_dup", int'(exec_dup), 0);
    chk("t2 dup_cnt",          int'(dup_cnt),  5);
    chk("t2 ready now",        int'(qed_ready), 1);
    step(0, 1, 0, 0, c_nop);
    ready_seen += int'(qed_ready);
    chk("t2 ready pulses", ready_seen, 1);

    // 3. NOPs and stalls do not store
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, c_nop);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, c_op);
    chk("t3 pending",  int'(pending),  0);
    chk("t3 orig_cnt", int'(orig_cnt), 5);

    // 4. fill to capacity without a request
    for (int i = 0; i < 127; i++) step(0, 1, 0, 0, c_op);
    chk("t4 forced dup", int'(exec_dup), 1);
    chk("t4 pending",    int'(pending),  127);
    chk("t4 orig_cnt",   int'(orig_cnt), 132);
    for (int i = 0; i < 127; i++) step(0, 1, 0, 0, c_op);
    chk("t4 drained",    int'(exec_dup), 0);
    chk("t4 orig final", int'(orig_cnt), 132);
    chk("t4 dup final",  int'(dup_cnt),  132);
    chk("t4 ready",      int'(qed_ready), 1);

    // 5. reset in the middle of a batch
    for (int i = 0; i < 3; i++) step(0, 1, 0, (i == 2), c_op);
    chk("t5 in dup", int'(exec_dup), 1);
    step(1, 1, 0, 0, c_op);
    chk("t5 exec_dup", int'(exec_dup), 0);
    chk("t5 pending",  int'(pending),  0);
    chk("t5 orig_cnt", int'(orig_cnt), 0);
    chk("t5 dup_cnt",  int'(dup_cnt),  0);

    // 6. empty switch ignored; disable while replaying drains to off
    step(0, 1, 0, 0, c_nop);
    step(0, 1, 0, 1, c_nop);
    chk("t6 empty switch", int'(exec_dup), 0);
    step(0, 1, 0, 0, c_op);
    step(0, 1, 0, 1, c_op);
    chk("t6 in dup", int'(exec_dup), 1);
    step(0, 0, 0, 0, c_op);
    chk("t6 still dup", int'(exec_dup), 1);
    step(0, 0, 0, 0, c_op);
    chk("t6 off",       int'(exec_dup), 0);
    chk("t6 ready",     int'(qed_ready), 1);
    step(0, 0, 0, 0, c_op);
    chk("t6 off no store", int'(pending), 0);
    chk("t6 orig_cnt",     int'(orig_cnt), 2);

    // random traffic: frequent switching, then rare switching to reach full
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 3000; i++) begin
        logic [31:0] instr;
        instr = $urandom;
        if ($urandom_range(4, 0) == 0) instr[6:0] = 7'h7F;
        step(($urandom_range(599, 0) == 0),
             ($urandom_range(59, 0) != 0),
             ($urandom_range(3, 0) == 0),
             (ph == 0) ? ($urandom_range(15, 0) == 0) : ($urandom_range(299, 0) == 0),
             instr);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
